// File: rtl/ibus_responder.sv
// ibus_responder: memory side of the instruction-bus handshake.
// Takes one word fetch at a time, waits Latency cycles, then answers with one
// RESP cycle that carries the word from an internal word array. A misaligned or
// out-of-range fetch answers with data 0 and fault set. A side load port writes
// the array in any state.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ireq_valid_i/addr_i    fetch request (valid, byte address)
//   iresp_addr_ok_o        high for the single RESP cycle
//   iresp_data_ok_o        high for the single RESP cycle
//   iresp_data_o           captured word; holds its value between responses
//   fault_o                high in RESP when the fetch was bad
//   ld_en_i/idx_i/data_i   load-port word write
//   served_o               number of responses issued, wraps modulo 2^32
module ibus_responder #(
  parameter logic [31:0] BaseAddr   = 32'h8000_0000,
  parameter int unsigned DepthWords = 16384,
  parameter int unsigned Latency    = 2,
  localparam int unsigned IdxW      = $clog2(DepthWords)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ireq_valid_i,
  input  logic [31:0]     ireq_addr_i,
  output logic            iresp_addr_ok_o,
  output logic            iresp_data_ok_o,
  output logic [31:0]     iresp_data_o,
  output logic            fault_o,
  input  logic            ld_en_i,
  input  logic [IdxW-1:0] ld_idx_i,
  input  logic [31:0]     ld_data_i,
  output logic [31:0]     served_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  logic [31:0] served_q, served_d;

  logic [31:0] mem_q [DepthWords];

  logic [31:0] idx;
  logic        bad;
  logic        capture;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      StIdle: begin
        if (ireq_valid_i) begin
          req_addr_d = ireq_addr_i;
          cnt_d      = 4'(Latency);
          state_d    = (Latency == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (!ireq_valid_i) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture uses req_addr_d so that Latency = 0 sees the address being
  // accepted at this same edge. RESP never follows RESP, so entering RESP is
  // simply state_d == StResp.
  always_comb begin
    capture  = (state_d == StResp);
    idx      = (req_addr_d - BaseAddr) >> 2;
    bad      = (req_addr_d[1:0] != 2'b00) || (req_addr_d < BaseAddr) ||
               (idx >= 32'(DepthWords));
    data_d   = data_q;
    fault_d  = 1'b0;
    if (capture) begin
      // mem_q read here is the pre-write value if a load hits the same word.
      data_d  = bad ? 32'h0 : mem_q[idx[IdxW-1:0]];
      fault_d = bad;
    end
    served_d = served_q + ((state_q == StResp) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      req_addr_q <= 32'h0;
      data_q     <= 32'h0;
      fault_q    <= 1'b0;
      served_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
      served_q   <= served_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) mem_q[ld_idx_i] <= ld_data_i;
  end

  assign iresp_addr_ok_o = (state_q == StResp);
  assign iresp_data_ok_o = (state_q == StResp);
  assign iresp_data_o    = data_q;
  assign fault_o         = fault_q;
  assign served_o        = served_q;

endmodule

// File: tb/tb_ibus_responder.sv
module tb_ibus_responder;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;

  // Index 0: Latency 0, 1: Latency 2, 2: Latency 4. All share the stimulus.
  logic        aok   [3];
  logic        dok   [3];
  logic [31:0] rdata [3];
  logic        flt   [3];
  logic [31:0] srv   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ibus_responder #(.BaseAddr(32'h8000_0000), .DepthWords(Depth), .Latency(0)) u_l0 (
    .clk_i(clk), .rst_ni(rst_n), .ireq_valid_i(valid), .ireq_addr_i(addr),
    .iresp_addr_ok_o(aok[0]), .iresp_data_ok_o(dok[0]), .iresp_data_o(rdata[0]),
    .fault_o(flt[0]), .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data),
    .served_o(srv[0])
  );

  ibus_responder #(.BaseAddr(32'h8000_0000), .DepthWords(Depth), .Latency(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .ireq_valid_i(valid), .ireq_addr_i(addr),
    .iresp_addr_ok_o(aok[1]), .iresp_data_ok_o(dok[1]), .iresp_data_o(rdata[1]),
    .fault_o(flt[1]), .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data),
    .served_o(srv[1])
  );

  ibus_responder #(.BaseAddr(32'h8000_0000), .DepthWords(Depth), .Latency(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .ireq_valid_i(valid), .ireq_addr_i(addr),
    .iresp_addr_ok_o(aok[2]), .iresp_data_ok_o(dok[2]), .iresp_data_o(rdata[2]),
    .fault_o(flt[2]), .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data),
    .served_o(srv[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    ld_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [3:0] idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_idx  = idx;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Returns the number of cycles from the current cycle to the RESP cycle.
  task automatic wait_resp(input int w, input string tag, output int n);
    n = 0;
    while (!aok[w] && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_resp"}, 32'(aok[w]), 32'd1);
  endtask

  // One fetch held until its response, then valid dropped.
  task automatic fetch(input int w, input string tag, input logic [31:0] a,
                       input logic [31:0] exp_data, input logic exp_fault, input int exp_lat);
    int n;
    valid = 1'b1;
    addr  = a;
    wait_resp(w, tag, n);
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_data"}, rdata[w], exp_data);
    check_eq({tag, "_fault"}, 32'(flt[w]), 32'(exp_fault));
    check_eq({tag, "_dok"}, 32'(dok[w]), 32'd1);
    valid = 1'b0;
    tick();
    check_eq({tag, "_idle_ok"}, {30'd0, aok[w], flt[w]}, 32'd0);
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n   = 1'b0;
    valid   = 1'b0;
    addr    = 32'h0;
    ld_en   = 1'b0;
    ld_idx  = 4'd0;
    ld_data = 32'h0;
    tick();
    tick();
    check_eq("rst_ok", {29'd0, aok[1], dok[1], flt[1]}, 32'd0);
    check_eq("rst_data", rdata[1], 32'h0);
    check_eq("rst_served", srv[1], 32'h0);
    rst_n = 1'b1;

    // Basic fetch, Latency 2.
    load(4'd0, 32'h0000_0013);
    fetch(1, "basic", 32'h8000_0000, 32'h0000_0013, 1'b0, 3);
    check_eq("basic_served", srv[1], 32'd1);
    check_eq("basic_hold", rdata[1], 32'h0000_0013);

    // Latency 0, back-to-back with valid held.
    do_reset();
    load(4'd1, 32'h1111_1111);
    load(4'd2, 32'h2222_2222);
    valid = 1'b1;
    addr  = 32'h8000_0004;
    tick();
    check_eq("b2b_r1_ok", 32'(aok[0]), 32'd1);
    check_eq("b2b_r1_data", rdata[0], 32'h1111_1111);
    addr = 32'h8000_0008;
    tick();
    check_eq("b2b_turn_ok", 32'(aok[0]), 32'd0);
    tick();
    check_eq("b2b_r2_ok", 32'(aok[0]), 32'd1);
    check_eq("b2b_r2_data", rdata[0], 32'h2222_2222);
    valid = 1'b0;
    tick();
    check_eq("b2b_served", srv[0], 32'd2);

    // Faults: misaligned, below base, one past the end; then the last word.
    do_reset();
    load(4'd15, 32'hCAFE_F00D);
    fetch(1, "f_misal", 32'h8000_0002, 32'h0, 1'b1, 3);
    fetch(1, "f_below", 32'h7FFF_FFFC, 32'h0, 1'b1, 3);
    fetch(1, "f_past", 32'h8000_0040, 32'h0, 1'b1, 3);
    check_eq("f_served", srv[1], 32'd3);
    fetch(1, "last_word", 32'h8000_003C, 32'hCAFE_F00D, 1'b0, 3);
    check_eq("last_served", srv[1], 32'd4);

    // Abort, Latency 4: valid dropped in the second WAIT cycle.
    do_reset();
    valid = 1'b1;
    addr  = 32'h8000_0004;
    tick();
    tick();
    valid = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | aok[2];
    end
    check_eq("abort_noresp", 32'(seen), 32'd0);
    check_eq("abort_served", srv[2], 32'd0);
    fetch(2, "after_abort", 32'h8000_0008, 32'h2222_2222, 1'b0, 5);
    check_eq("after_abort_served", srv[2], 32'd1);

    // Load collision at the capture edge, Latency 2.
    do_reset();
    load(4'd5, 32'hAAAA_AAAA);
    valid = 1'b1;
    addr  = 32'h8000_0014;
    tick();
    tick();
    ld_en   = 1'b1;
    ld_idx  = 4'd5;
    ld_data = 32'hBBBB_BBBB;
    tick();
    ld_en = 1'b0;
    check_eq("coll_ok", 32'(aok[1]), 32'd1);
    check_eq("coll_data", rdata[1], 32'hAAAA_AAAA);
    tick();
    check_eq("refetch_idle", 32'(aok[1]), 32'd0);
    wait_resp(1, "refetch", n);
    check_eq("refetch_lat", 32'(n), 32'd3);
    check_eq("refetch_data", rdata[1], 32'hBBBB_BBBB);
    valid = 1'b0;
    tick();
    check_eq("coll_served", srv[1], 32'd2);

    // Reset asserted mid-cycle during WAIT.
    valid = 1'b1;
    addr  = 32'h8000_0000;
    tick();
    #3;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check_eq("mid_rst_data", rdata[1], 32'h0);
    check_eq("mid_rst_served", srv[1], 32'h0);
    check_eq("mid_rst_ok", {30'd0, aok[1], flt[1]}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | aok[1];
    end
    check_eq("mid_rst_nostale", 32'(seen), 32'd0);
    fetch(1, "keep_mem0", 32'h8000_0000, 32'h0000_0013, 1'b0, 3);
    fetch(1, "keep_mem5", 32'h8000_0014, 32'hBBBB_BBBB, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
